branch_unit_ctrl: RTL

BRANCH_UNIT_CTRL -- requirements
Module: branch_unit_ctrl

---
 rtl/branch_unit_ctrl_pkg.sv | 21 ++
 rtl/branch_cmp_eval.sv | 24 ++
 rtl/branch_unit_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/branch_unit_ctrl_pkg.sv
// rtl/branch_unit_ctrl_pkg.sv - shared ALU and compare op encodings for the branch unit
package branch_unit_ctrl_pkg;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4
  } alu_op_e;

  typedef enum logic [2:0] {
    CMP_NOP = 3'd0,
    CMP_EQ  = 3'd1,
    CMP_NE  = 3'd2,
    CMP_LT  = 3'd3,
    CMP_GE  = 3'd4,
    CMP_LTU = 3'd5,
    CMP_GEU = 3'd6
  } cmp_op_e;

endpackage

// File: rtl/branch_cmp_eval.sv
// rtl/branch_cmp_eval.sv - maps an ALU result to a branch outcome for a compare op
module branch_cmp_eval
  import branch_unit_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      cmp_op,
  input  logic [XLEN-1:0] result,
  output logic            taken
);

  // EQ/NE look at the XOR result; the ordered compares look at the SLT/SLTU flag bit.
  always_comb begin
    taken = 1'b0;
    case (cmp_op)
      CMP_EQ:          taken = (result == '0);
      CMP_NE:          taken = (result != '0);
      CMP_LT, CMP_LTU: taken = result[0];
      CMP_GE, CMP_GEU: taken = !result[0];
      default:         taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_unit_ctrl.sv
// rtl/branch_unit_ctrl.sv - branch resolution controller sharing an external ALU
module branch_unit_ctrl
  import branch_unit_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            br_valid,
  output logic            br_ready,
  input  logic [XLEN-1:0] br_pc,
  input  logic [XLEN-1:0] br_imm,
  input  logic [3:0]      br_alu_op,
  input  logic [2:0]      br_cmp_op,
  input  logic [XLEN-1:0] br_rs1_val,
  input  logic [XLEN-1:0] br_rs2_val,
  input  logic            flush,
  output logic            alu_req,
  input  logic            alu_gnt,
  output logic [3:0]      alu_op_o,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic            alu_done,
  input  logic [XLEN-1:0] alu_result,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            taken,
  output logic            busy,
  output logic            timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ALU_REQ, S_ALU_WAIT, S_RESOLVE, S_DRAIN
  } state_e;

  localparam int CW = $clog2(WAIT_LIMIT + 1);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q, redirect_pc_q;
  logic [3:0]      alu_op_q;
  logic [2:0]      cmp_op_q;
  logic [CW-1:0]   cnt_q;
  logic            taken_q, timeout_q;
  logic            handshake, alu_taken, drive_alu;

  assign handshake = br_valid && (state_q == S_IDLE) && !flush;
  assign drive_alu = (state_q == S_ALU_REQ) || (state_q == S_ALU_WAIT);

  branch_cmp_eval #(.XLEN(XLEN)) u_cmp_eval (
    .cmp_op (cmp_op_q),
    .result (alu_result),
    .taken  (alu_taken)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      alu_op_q      <= '0;
      cmp_op_q      <= '0;
      cnt_q         <= '0;
      redirect_pc_q <= '0;
      taken_q       <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: if (handshake) begin
          pc_q     <= br_pc;
          imm_q    <= br_imm;
          rs1_q    <= br_rs1_val;
          rs2_q    <= br_rs2_val;
          alu_op_q <= br_alu_op;
          cmp_op_q <= br_cmp_op;
          if (br_cmp_op == CMP_NOP) begin
            taken_q       <= 1'b0;
            redirect_pc_q <= br_pc + PC_STEP;
            state_q       <= S_RESOLVE;
          end else begin
            state_q <= S_ALU_REQ;
          end
        end
        S_ALU_REQ: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else if (alu_gnt) begin
            cnt_q   <= '0;
            state_q <= S_ALU_WAIT;
          end
        end
        S_ALU_WAIT: begin
          // A flush still owes the ALU its completion, so drain unless it lands this cycle.
          if (flush) begin
            state_q <= alu_done ? S_IDLE : S_DRAIN;
          end else if (alu_done) begin
            taken_q       <= alu_taken;
            redirect_pc_q <= alu_taken ? pc_q + imm_q : pc_q + PC_STEP;
            state_q       <= S_RESOLVE;
          end else if (cnt_q == CW'(WAIT_LIMIT - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= S_DRAIN;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_RESOLVE: state_q <= S_IDLE;
        S_DRAIN:   if (alu_done) state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  assign br_ready       = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign alu_req        = (state_q == S_ALU_REQ);
  assign alu_op_o       = drive_alu ? alu_op_q : '0;
  assign alu_a          = drive_alu ? rs1_q : '0;
  assign alu_b          = drive_alu ? rs2_q : '0;
  assign redirect_valid = (state_q == S_RESOLVE) && !flush;
  assign redirect_pc    = redirect_pc_q;
  assign taken          = taken_q;
  assign timeout_err    = timeout_q;

endmodule
